paddle_ctrl: RTL and testbench
==============================

# paddle_ctrl

Input sequencer for both Pong paddles. It synchronizes and debounces the raw player buttons and runs a game-run state machine (idle/run/paused). It issues one-cycle move strobes, at most one per frame per paddle, to the two paddle position instances. When the AI option is compiled in, it drives paddle 2 by tracking the ball instead of using the player-2 buttons.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive cycles a synchronized input must hold a new level before the debounced value changes (minimum 2).
- PADDLE_HEIGHT, 60: paddle height in pixels, used by AI centering.
- AI_DEADBAND, 4: AI tolerance in pixels around the paddle center.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- btn_p1_up, btn_p1_dn, btn_p2_up, btn_p2_dn, btn_pause  in  1 each  raw asynchronous buttons, active-high
- ball_y  in  10  ball top y (AI only)
- p2_y  in  10  current paddle-2 top y (AI only)
- p1_move_up, p1_move_down, p2_move_up, p2_move_down  out  1 each  one-cycle move strobes to the paddle instances
- paused  out  1  high in IDLE and PAUSED

## Operation
- **Input path.** Each button passes through a 2-flop synchronizer, then its own debouncer.
- **Debouncer.** It keeps a stable bit and a counter of width $clog2(DEBOUNCE_CYCLES).
  - If the synchronized value equals stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable flips and the counter clears.
- **FSM states:** IDLE, RUN, PAUSED.
  - IDLE to RUN: rising edge of any debounced button.
  - RUN to PAUSED: rising edge of debounced pause.
  - PAUSED to RUN: rising edge of debounced pause.
- **Strobe generation.** On a frame_tick cycle with the state RUN, and no state transition in that same cycle:
  - Each player's direction is evaluated from its debounced up/dn bits.
  - Up only: up strobe. Down only: down strobe. Both or neither: no strobe.
- **Strobe rules.**
  - Strobes are registered and last exactly one cycle.
  - Up and down are never asserted together for one paddle.
  - No strobes are issued in IDLE or PAUSED.
- **Bounds.** This block does not check paddle bounds; the paddle instance clamps.

## Timing
- Reset values: all strobes 0, paused 1, state IDLE, all stable bits 0, counters 0, synchronizers 0.
- Button to debounced value: 2 synchronizer cycles plus DEBOUNCE_CYCLES cycles of stable level.
- A glitch shorter than DEBOUNCE_CYCLES clears the counter and produces no change.
- Debounced edge to state change: the state register updates at the next clk edge.
- frame_tick (cycle T) to strobe: the strobe is high during cycle T+1 only.
- Simultaneous pause edge and frame_tick: the transition wins and no strobe is issued that frame.
  - This holds for both RUN to PAUSED and PAUSED to RUN.
- frame_tick during the debounce window: the old stable value is used.
- Reset mid-operation: all outputs drop to their reset values asynchronously. Any pending strobe is lost.
- After reset deasserts, the block is in IDLE and requires a fresh debounced press.

## Configuration
- **Macro PADDLE_AI_EN defined:**
  - btn_p2_up and btn_p2_dn are ignored: they do not feed paddle-2 strobes and do not trigger IDLE to RUN.
  - On a qualifying frame_tick, center = p2_y + PADDLE_HEIGHT/2, computed in 11 bits with no overflow.
  - If {1'b0,ball_y} + AI_DEADBAND < center: p2_move_up.
  - If {1'b0,ball_y} > center + AI_DEADBAND: p2_move_down.
  - Otherwise no strobe.
  - Inputs are sampled in the frame_tick cycle.
- **Macro undefined:**
  - Paddle 2 uses the debounced buttons exactly like paddle 1.
  - ball_y and p2_y are unused.

## Test plan
Directed scenarios, all with DEBOUNCE_CYCLES=4:
- **Reset state.** Assert rst at an arbitrary cycle -> strobes 0 and paused=1 the same cycle. Pulse frame_tick after release -> no strobes.
- **Start and strobe.** Hold btn_p1_up for 10 cycles -> state RUN and paused=0. Then frame_tick at T -> p1_move_up=1 at T+1 only. No strobe on a cycle without frame_tick.
- **Glitch rejection.** In RUN, pulse btn_p1_dn for 3 cycles, then frame_tick -> no strobe. Both p1 buttons held, then frame_tick -> no strobe.
- **Pause toggle.** Press pause, then 3 frame_ticks -> paused=1 and zero strobes. Press again -> RUN, and the next frame_tick yields a strobe. Pause edge coincident with frame_tick -> no strobe that frame.
- **AI, PADDLE_AI_EN.** In RUN with p2_y=200 (center 230):
  - ball_y=100 -> p2_move_up.
  - ball_y=300 -> p2_move_down.
  - ball_y=228 -> none.
  - ball_y=234 -> none.
  - ball_y=235 -> p2_move_down.
  - btn_p2_dn held -> ignored.
- **Reset mid-operation.** Hold btn_p1_up in RUN and assert rst in the cycle after frame_tick -> strobe drops immediately and state returns to IDLE.

Source files
------------

// File: rtl/paddle_ctrl.sv
// Pong paddle input sequencer: button sync/debounce, idle/run/paused FSM,
// and one-cycle per-frame move strobes for both paddles.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   frame_tick          one-cycle pulse per video frame
//   btn_p1_up/dn        raw player-1 buttons
//   btn_p2_up/dn        raw player-2 buttons (ignored with PADDLE_AI_EN)
//   btn_pause           raw pause/start button
//   ball_y, p2_y        ball and paddle-2 top y (used with PADDLE_AI_EN)
//   p1_move_up/down     paddle-1 move strobes
//   p2_move_up/down     paddle-2 move strobes
//   paused              high in IDLE and PAUSED
//
// Build option: define PADDLE_AI_EN to let paddle 2 track the ball.
module paddle_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PADDLE_HEIGHT   = 60,
  parameter int AI_DEADBAND     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_p1_up,
  input  logic       btn_p1_dn,
  input  logic       btn_p2_up,
  input  logic       btn_p2_dn,
  input  logic       btn_pause,
  input  logic [9:0] ball_y,
  input  logic [9:0] p2_y,
  output logic       p1_move_up,
  output logic       p1_move_down,
  output logic       p2_move_up,
  output logic       p2_move_down,
  output logic       paused
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } state_t;

  // Bit order: 0 p1_up, 1 p1_dn, 2 p2_up, 3 p2_dn, 4 pause
  logic [4:0]    raw;
  logic [4:0]    s1;
  logic [4:0]    s2;
  logic [4:0]    stable;
  logic [4:0]    stable_q;
  logic [4:0]    rise;
  logic [CW-1:0] cnt [5];

  state_t state;
  state_t nxt;

  logic start;
  logic go;
  logic p1_up;
  logic p1_dn;
  logic p2_up;
  logic p2_dn;

  assign raw = {btn_pause, btn_p2_dn, btn_p2_up,
                btn_p1_dn, btn_p1_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_q <= stable;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CMAX) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise  = stable & ~stable_q;
  assign p1_up = stable[0] & ~stable[1];
  assign p1_dn = stable[1] & ~stable[0];

`ifdef PADDLE_AI_EN
  logic [10:0] center;
  logic [10:0] ball_w;
  logic        unused_p2_btn;

  assign center = {1'b0, p2_y} + 11'(PADDLE_HEIGHT / 2);
  assign ball_w = {1'b0, ball_y};
  assign p2_up  = (ball_w + 11'(AI_DEADBAND)) < center;
  assign p2_dn  = ball_w > (center + 11'(AI_DEADBAND));
  assign start  = |(rise & 5'b10011);
  assign unused_p2_btn = ^{stable[3:2], stable_q[3:2]};
`else
  logic unused_ai;

  assign p2_up = stable[2] & ~stable[3];
  assign p2_dn = stable[3] & ~stable[2];
  assign start = |rise;
  assign unused_ai = ^{ball_y, p2_y};
`endif

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start)   nxt = RUN;
      RUN:     if (rise[4]) nxt = PAUSED;
      PAUSED:  if (rise[4]) nxt = RUN;
      default: nxt = IDLE;
    endcase
  end

  // A pause/resume edge in the tick cycle suppresses that frame's move.
  assign go = frame_tick && (state == RUN) && (nxt == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      paused       <= 1'b1;
      p1_move_up   <= 1'b0;
      p1_move_down <= 1'b0;
      p2_move_up   <= 1'b0;
      p2_move_down <= 1'b0;
    end else begin
      state        <= nxt;
      paused       <= (nxt != RUN);
      p1_move_up   <= go & p1_up;
      p1_move_down <= go & p1_dn;
      p2_move_up   <= go & p2_up;
      p2_move_down <= go & p2_dn;
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl with DEBOUNCE_CYCLES=4.
// Inputs change after the falling edge; outputs are checked there too.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_p1_up = 1'b0;
  logic       btn_p1_dn = 1'b0;
  logic       btn_p2_up = 1'b0;
  logic       btn_p2_dn = 1'b0;
  logic       btn_pause = 1'b0;
  logic [9:0] ball_y = 10'd230;
  logic [9:0] p2_y = 10'd200;
  logic       p1_move_up;
  logic       p1_move_down;
  logic       p2_move_up;
  logic       p2_move_down;
  logic       paused;

  int checks = 0;
  int errors = 0;

  logic [3:0] strb;
  assign strb = {p1_move_up, p1_move_down, p2_move_up, p2_move_down};

  paddle_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .PADDLE_HEIGHT(60),
    .AI_DEADBAND(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .btn_p1_up(btn_p1_up),
    .btn_p1_dn(btn_p1_dn),
    .btn_p2_up(btn_p2_up),
    .btn_p2_dn(btn_p2_dn),
    .btn_pause(btn_pause),
    .ball_y(ball_y),
    .p2_y(p2_y),
    .p1_move_up(p1_move_up),
    .p1_move_down(p1_move_down),
    .p2_move_up(p2_move_up),
    .p2_move_down(p2_move_down),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full press and release of pause, long enough to debounce both edges.
  task automatic press_pause();
    btn_pause = 1'b1;
    cyc(8);
    btn_pause = 1'b0;
    cyc(8);
  endtask

  // One frame tick; returns strobes seen in the following cycle.
  task automatic tick(output logic [3:0] s);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    s = strb;
  endtask

  logic [3:0] s;
  logic [9:0] ai_ball [7];
  logic [1:0] ai_exp  [7];

  initial begin
    ai_ball = '{10'd100, 10'd300, 10'd228, 10'd234,
                10'd235, 10'd226, 10'd225};
`ifdef PADDLE_AI_EN
    ai_exp  = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
`else
    ai_exp  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`endif

    // Reset state
    cyc(2);
    chk("rst_strobes", strb, 4'b0000);
    chk("rst_paused", {3'b0, paused}, 4'b0001);
    rst = 1'b0;
    cyc(2);
    tick(s);
    chk("idle_tick", s, 4'b0000);
    chk("idle_paused", {3'b0, paused}, 4'b0001);

    // Start and strobe
    btn_p1_up = 1'b1;
    cyc(10);
    chk("run_paused", {3'b0, paused}, 4'b0000);
    tick(s);
    chk("p1_up_strobe", s, 4'b1000);
    cyc(1);
    chk("p1_up_one_cycle", strb, 4'b0000);
    cyc(3);
    chk("no_tick_no_strobe", strb, 4'b0000);

    // Glitch rejection
    btn_p1_up = 1'b0;
    cyc(8);
    btn_p1_dn = 1'b1;
    cyc(3);
    btn_p1_dn = 1'b0;
    cyc(4);
    tick(s);
    chk("glitch", s, 4'b0000);
    btn_p1_up = 1'b1;
    btn_p1_dn = 1'b1;
    cyc(10);
    tick(s);
    chk("both_p1", s, 4'b0000);

    // Player 2 down button, paddle 1 down
    btn_p1_up = 1'b0;
    btn_p2_dn = 1'b1;
    cyc(10);
    tick(s);
`ifdef PADDLE_AI_EN
    chk("p2_btn", s, 4'b0100);
`else
    chk("p2_btn", s, 4'b0101);
`endif

    // Pause toggle
    press_pause();
    chk("pause_paused", {3'b0, paused}, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick(s);
      chk("paused_tick", s, 4'b0000);
      cyc(2);
    end
    press_pause();
    chk("resume_paused", {3'b0, paused}, 4'b0000);
    tick(s);
`ifdef PADDLE_AI_EN
    chk("resume_strobe", s, 4'b0100);
`else
    chk("resume_strobe", s, 4'b0101);
`endif

    // Pause edge coincident with frame_tick, both directions.
    // The debounced rise is visible 6 edges after the press.
    btn_pause = 1'b1;
    cyc(6);
    tick(s);
    chk("coinc_pause_strb", s, 4'b0000);
    chk("coinc_pause_state", {3'b0, paused}, 4'b0001);
    btn_pause = 1'b0;
    cyc(8);
    btn_pause = 1'b1;
    cyc(6);
    tick(s);
    chk("coinc_resume_strb", s, 4'b0000);
    chk("coinc_resume_state", {3'b0, paused}, 4'b0000);
    btn_pause = 1'b0;
    cyc(8);

    // Ball tracking (no effect on paddle 2 without the AI option)
    btn_p1_dn = 1'b0;
    btn_p2_dn = 1'b0;
    cyc(8);
    p2_y = 10'd200;
    for (int i = 0; i < 7; i++) begin
      ball_y = ai_ball[i];
      tick(s);
      chk("ai_track", s, {2'b00, ai_exp[i]});
      cyc(1);
    end

    // Reset mid-operation
    btn_p1_up = 1'b1;
    cyc(10);
    tick(s);
    chk("pre_rst_strobe", s, 4'b1000);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_strobe", strb, 4'b0000);
    chk("async_rst_paused", {3'b0, paused}, 4'b0001);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_idle", {3'b0, paused}, 4'b0001);
    tick(s);
    chk("post_rst_tick", s, 4'b0000);
    cyc(8);
    chk("post_rst_fresh_run", {3'b0, paused}, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
